// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 round scheduler:
// round bounds, widths, scheduler states and requester source tags.
package aes_pkg;

    localparam int SENTENCE   = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int ROUND_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_HOLD  = 2'd2
    } sched_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Grant vectors are one-hot with bit 0 = A and bit 1 = B.
    function automatic logic grant_to_src(input logic [1:0] grant);
        logic src;
        if (grant[1]) begin
            src = SRC_B;
        end else begin
            src = SRC_A;
        end
        return src;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever requester was not served last. Purely combinational.
module rr_arbiter_2
    import aes_pkg::*;
(
    input  logic       valid_a_i,
    input  logic       valid_b_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    // One-hot grant selection from the two valids and the last-served pointer.
    always_comb begin
        grant_o = 2'b00;
        if (valid_a_i && valid_b_i) begin
            if (last_i == SRC_B) begin
                grant_o = 2'b01;
            end else begin
                grant_o = 2'b10;
            end
        end else if (valid_a_i) begin
            grant_o = 2'b01;
        end else if (valid_b_i) begin
            grant_o = 2'b10;
        end else begin
            grant_o = 2'b00;
        end
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Sequencer and round-robin arbiter for a shared iterative AES-128 datapath:
// accepts one job at a time, steps rounds 0..NUM_ROUNDS, returns the tagged result.
module aes_round_scheduler #(
    parameter int SENTENCE   = aes_pkg::SENTENCE,
    parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
    parameter int ROUND_W    = aes_pkg::ROUND_W
) (
    input  logic                CLK,
    input  logic                Rst_n,
    input  logic                Req_A_Valid,
    output logic                Req_A_Ready,
    input  logic [SENTENCE-1:0] Req_A_Text,
    input  logic [SENTENCE-1:0] Req_A_Key,
    input  logic                Req_B_Valid,
    output logic                Req_B_Ready,
    input  logic [SENTENCE-1:0] Req_B_Text,
    input  logic [SENTENCE-1:0] Req_B_Key,
    output logic [ROUND_W-1:0]  Dp_Round,
    output logic [SENTENCE-1:0] Dp_Text,
    output logic [SENTENCE-1:0] Dp_Key,
    output logic                Dp_Busy,
    input  logic [SENTENCE-1:0] Dp_Result,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [SENTENCE-1:0] Out_Data,
    output logic                Out_Src
);

    import aes_pkg::*;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] ROUND_ONE  = ROUND_W'(1);
    localparam logic [ROUND_W-1:0] ROUND_ZERO = ROUND_W'(0);

    sched_state_e        state_q, state_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [SENTENCE-1:0] text_q, text_d;
    logic [SENTENCE-1:0] key_q, key_d;
    logic                busy_q, busy_d;
    logic                src_q, src_d;
    logic                last_q, last_d;
    logic                out_valid_q, out_valid_d;
    logic [SENTENCE-1:0] out_data_q, out_data_d;
    logic                out_src_q, out_src_d;

    logic [1:0]          grant_s;
    logic                idle_s;

    rr_arbiter_2 u_arb (
        .valid_a_i (Req_A_Valid),
        .valid_b_i (Req_B_Valid),
        .last_i    (last_q),
        .grant_o   (grant_s)
    );

    // Ready is only offered in IDLE and never while reset is held.
    assign idle_s      = (state_q == ST_IDLE) && Rst_n;
    assign Req_A_Ready = idle_s && grant_s[0];
    assign Req_B_Ready = idle_s && grant_s[1];

    // Next-state logic: accept in IDLE, count rounds, capture result, drain.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        text_d      = text_q;
        key_d       = key_q;
        busy_d      = busy_q;
        src_d       = src_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    if (grant_s[1]) begin
                        text_d = Req_B_Text;
                        key_d  = Req_B_Key;
                    end else begin
                        text_d = Req_A_Text;
                        key_d  = Req_A_Key;
                    end
                    src_d   = grant_to_src(grant_s);
                    last_d  = grant_to_src(grant_s);
                    round_d = ROUND_ZERO;
                    busy_d  = 1'b1;
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (round_q < LAST_ROUND) begin
                    round_d = round_q + ROUND_ONE;
                end else begin
                    // Dp_Result is the final AddRoundKey output during the last round.
                    out_data_d  = Dp_Result;
                    out_src_d   = src_q;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    round_d     = ROUND_ZERO;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                round_d     = ROUND_ZERO;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; async reset discards any job in flight.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= ST_IDLE;
            round_q     <= ROUND_ZERO;
            text_q      <= {SENTENCE{1'b0}};
            key_q       <= {SENTENCE{1'b0}};
            busy_q      <= 1'b0;
            src_q       <= SRC_A;
            last_q      <= SRC_B;
            out_valid_q <= 1'b0;
            out_data_q  <= {SENTENCE{1'b0}};
            out_src_q   <= SRC_A;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            text_q      <= text_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
            src_q       <= src_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign Dp_Round  = round_q;
    assign Dp_Text   = text_q;
    assign Dp_Key    = key_q;
    assign Dp_Busy   = busy_q;
    assign Out_Valid = out_valid_q;
    assign Out_Data  = out_data_q;
    assign Out_Src   = out_src_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: attaches an AES-128 round datapath model and
// compares every output each cycle against a job-level reference model.
module tb_aes_round_scheduler;

    localparam int W = 128;
    localparam logic [W-1:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [W-1:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         CLK = 1'b0;
    logic         Rst_n = 1'b1;
    logic         Req_A_Valid = 1'b0;
    logic         Req_B_Valid = 1'b0;
    logic         Req_A_Ready, Req_B_Ready;
    logic [W-1:0] Req_A_Text = '0, Req_A_Key = '0, Req_B_Text = '0, Req_B_Key = '0;
    logic [3:0]   Dp_Round;
    logic [W-1:0] Dp_Text, Dp_Key, Dp_Result;
    logic         Dp_Busy;
    logic         Out_Valid;
    logic         Out_Ready = 1'b0;
    logic [W-1:0] Out_Data;
    logic         Out_Src;

    int n_pass = 0;
    int n_total = 0;
    logic chk_en = 1'b0;
    logic mon_en = 1'b0;
    int cyc = 0;
    logic [7:0] sbox_t [256];
    logic mon_src [$];
    int   mon_cyc [$];

    aes_round_scheduler dut (
        .CLK(CLK), .Rst_n(Rst_n),
        .Req_A_Valid(Req_A_Valid), .Req_A_Ready(Req_A_Ready), .Req_A_Text(Req_A_Text), .Req_A_Key(Req_A_Key),
        .Req_B_Valid(Req_B_Valid), .Req_B_Ready(Req_B_Ready), .Req_B_Text(Req_B_Text), .Req_B_Key(Req_B_Key),
        .Dp_Round(Dp_Round), .Dp_Text(Dp_Text), .Dp_Key(Dp_Key), .Dp_Busy(Dp_Busy), .Dp_Result(Dp_Result),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_Src(Out_Src)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gbyte(input logic [W-1:0] s, input int i);
        return s[W-1-8*i -: 8];
    endfunction

    function automatic logic [W-1:0] aes_round(input logic [W-1:0] s, input logic [W-1:0] rk, input logic last);
        logic [W-1:0] t;
        logic [W-1:0] m;
        logic [7:0] a0, a1, a2, a3;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[W-1-8*(r+4*c) -: 8] = sbox_t[gbyte(s, r + 4*((c + r) % 4))];
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = gbyte(t, 4*c);
                a1 = gbyte(t, 4*c+1);
                a2 = gbyte(t, 4*c+2);
                a3 = gbyte(t, 4*c+3);
                m[W-1-32*c -: 8]  = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                m[W-9-32*c -: 8]  = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                m[W-17-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                m[W-25-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        return m ^ rk;
    endfunction

    function automatic logic [W-1:0] key_expand(input logic [W-1:0] k, input int rnd);
        logic [7:0] rc;
        logic [31:0] w0, w1, w2, w3, t;
        rc = 8'h01;
        for (int i = 1; i < rnd; i++) rc = xtime(rc);
        w3 = k[31:0];
        t = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [W-1:0] aes128_encrypt(input logic [W-1:0] pt, input logic [W-1:0] k);
        logic [W-1:0] s;
        logic [W-1:0] rk;
        s = pt ^ k;
        rk = k;
        for (int r = 1; r <= 10; r++) begin
            rk = key_expand(rk, r);
            s = aes_round(s, rk, r == 10);
        end
        return s;
    endfunction

    // ---------------- iterative datapath attached to the DUT ----------------
    logic [W-1:0] dp_st_q = '0;
    logic [W-1:0] dp_rk_q = '0;
    logic [W-1:0] dp_rk_s;
    assign dp_rk_s   = (Dp_Round == 4'd0) ? Dp_Key : key_expand(dp_rk_q, int'(Dp_Round));
    assign Dp_Result = (Dp_Round == 4'd0) ? (Dp_Text ^ Dp_Key)
                                          : aes_round(dp_st_q, dp_rk_s, Dp_Round == 4'd10);
    always @(posedge CLK) begin
        dp_st_q <= Dp_Result;
        dp_rk_q <= dp_rk_s;
    end

    // ---------------- job-level reference model ----------------
    logic m_active = 1'b0, m_hold = 1'b0, m_src = 1'b0, m_last = 1'b1, m_out_src = 1'b0;
    int   m_age = 0;
    logic [W-1:0] m_text = '0, m_key = '0, m_out = '0;
    logic [1:0] m_grant;

    function automatic logic [1:0] winner(input logic va, input logic vb, input logic last_was_b);
        if (va && vb) return last_was_b ? 2'b01 : 2'b10;
        if (va) return 2'b01;
        if (vb) return 2'b10;
        return 2'b00;
    endfunction

    assign m_grant = (Rst_n && !m_active && !m_hold) ? winner(Req_A_Valid, Req_B_Valid, m_last) : 2'b00;

    always @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            m_active <= 1'b0; m_hold <= 1'b0; m_age <= 0; m_src <= 1'b0; m_last <= 1'b1;
            m_text <= '0; m_key <= '0; m_out <= '0; m_out_src <= 1'b0;
        end else if (m_active) begin
            if (m_age == 10) begin
                m_active <= 1'b0; m_hold <= 1'b1; m_age <= 0;
                m_out <= aes128_encrypt(m_text, m_key);
                m_out_src <= m_src;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (m_hold) begin
            if (Out_Ready) m_hold <= 1'b0;
        end else if (m_grant != 2'b00) begin
            m_active <= 1'b1; m_age <= 0;
            m_src <= m_grant[1]; m_last <= m_grant[1];
            m_text <= m_grant[1] ? Req_B_Text : Req_A_Text;
            m_key  <= m_grant[1] ? Req_B_Key  : Req_A_Key;
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("Req_A_Ready", W'(Req_A_Ready), W'(m_grant[0]));
            check("Req_B_Ready", W'(Req_B_Ready), W'(m_grant[1]));
            check("Dp_Round", W'(Dp_Round), m_active ? W'(m_age) : W'(0));
            check("Dp_Busy", W'(Dp_Busy), W'(m_active));
            check("Dp_Text", Dp_Text, m_text);
            check("Dp_Key", Dp_Key, m_key);
            check("Out_Valid", W'(Out_Valid), W'(m_hold));
            check("Out_Data", Out_Data, m_out);
            check("Out_Src", W'(Out_Src), W'(m_out_src));
        end
    end

    always @(negedge CLK) begin
        if (mon_en && Out_Valid && Out_Ready) begin
            mon_src.push_back(Out_Src);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_out(input int max);
        for (int i = 0; i < max && !Out_Valid; i++) tick();
        check("out_valid_wait", W'(Out_Valid), W'(1'b1));
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        logic [7:0] inv;
        logic [W-1:0] t_s, k_s;

        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(b), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        check("model_sbox_00", W'(sbox_t[0]), W'(8'h63));
        check("model_sbox_53", W'(sbox_t[83]), W'(8'hed));
        check("model_fips", aes128_encrypt(FIPS_PT, FIPS_KEY), FIPS_CT);

        // Reset with both requesters asserting.
        #1 Rst_n = 1'b0;
        Req_A_Valid = 1'b1; Req_B_Valid = 1'b1;
        Req_A_Text = FIPS_PT; Req_A_Key = FIPS_KEY;
        Req_B_Text = rnd128(); Req_B_Key = rnd128();
        tick();
        chk_en = 1'b1;
        tick(); tick();
        check("rst_ready_a", W'(Req_A_Ready), W'(1'b0));
        check("rst_ready_b", W'(Req_B_Ready), W'(1'b0));
        check("rst_busy", W'(Dp_Busy), W'(1'b0));
        check("rst_out_valid", W'(Out_Valid), W'(1'b0));
        check("rst_dp_text", Dp_Text, W'(0));
        Rst_n = 1'b1;
        #1;
        check("post_rst_ready_a", W'(Req_A_Ready), W'(1'b1));
        check("post_rst_ready_b", W'(Req_B_Ready), W'(1'b0));

        // FIPS job from A; result held to exercise backpressure.
        tick();
        Req_A_Valid = 1'b0; Req_B_Valid = 1'b0;
        n = 0;
        while (!Out_Valid && n < 20) begin tick(); n++; end
        check("fips_latency", W'(n), W'(11));
        check("fips_data", Out_Data, FIPS_CT);
        check("fips_src", W'(Out_Src), W'(1'b0));

        Req_B_Valid = 1'b1; Req_B_Text = rnd128(); Req_B_Key = rnd128();
        t_s = Req_B_Text;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_data", Out_Data, FIPS_CT);
            check("bp_ready_b", W'(Req_B_Ready), W'(1'b0));
            check("bp_busy", W'(Dp_Busy), W'(1'b0));
        end
        Out_Ready = 1'b1;
        tick();
        check("bp_drain_valid", W'(Out_Valid), W'(1'b0));
        Out_Ready = 1'b0;
        tick();
        check("bp_accept_busy", W'(Dp_Busy), W'(1'b1));
        check("bp_accept_text", Dp_Text, t_s);
        Req_B_Valid = 1'b0;
        wait_out(20);
        check("bp_b_src", W'(Out_Src), W'(1'b1));
        Out_Ready = 1'b1; tick();

        // Contention: both valid for four jobs, Out_Ready held high.
        Req_A_Valid = 1'b1; Req_B_Valid = 1'b1; mon_en = 1'b1;
        cnt = 0;
        while (mon_src.size() < 4 && cnt < 80) begin tick(); cnt++; end
        Req_A_Valid = 1'b0; Req_B_Valid = 1'b0; mon_en = 1'b0;
        check("cont_count", W'(mon_src.size()), W'(4));
        for (int i = 0; i < mon_src.size() && i < 4; i++)
            check("cont_src", W'(mon_src[i]), W'(i % 2));
        for (int i = 1; i < mon_cyc.size() && i < 4; i++)
            check("cont_period", W'(mon_cyc[i] - mon_cyc[i-1]), W'(13));
        tick(); tick();
        Out_Ready = 1'b0;

        // Valid withdrawal during ROUND leaves the pointer untouched.
        Req_A_Valid = 1'b1; Req_A_Text = rnd128(); Req_A_Key = rnd128();
        tick();
        Req_A_Valid = 1'b0;
        repeat (3) tick();
        Req_B_Valid = 1'b1;
        #1;
        check("wd_ready_b", W'(Req_B_Ready), W'(1'b0));
        tick();
        Req_B_Valid = 1'b0;
        wait_out(20);
        check("wd_a_src", W'(Out_Src), W'(1'b0));
        Out_Ready = 1'b1; tick(); Out_Ready = 1'b0;
        Req_A_Valid = 1'b1; Req_B_Valid = 1'b1;
        #1;
        check("wd_tie_b", W'(Req_B_Ready), W'(1'b1));
        check("wd_tie_a", W'(Req_A_Ready), W'(1'b0));
        tick();
        Req_A_Valid = 1'b0; Req_B_Valid = 1'b0;
        wait_out(20);
        Out_Ready = 1'b1; tick(); Out_Ready = 1'b0;

        // Reset while the datapath is at round 5.
        Req_A_Valid = 1'b1; Req_A_Text = rnd128();
        tick();
        Req_A_Valid = 1'b0;
        cnt = 0;
        while (Dp_Round != 4'd5 && cnt < 20) begin tick(); cnt++; end
        check("mid_round5", W'(Dp_Round), W'(5));
        Rst_n = 1'b0;
        #1;
        check("mid_rst_round", W'(Dp_Round), W'(0));
        check("mid_rst_busy", W'(Dp_Busy), W'(1'b0));
        check("mid_rst_text", Dp_Text, W'(0));
        check("mid_rst_key", Dp_Key, W'(0));
        tick(); tick();
        Rst_n = 1'b1;
        t_s = rnd128(); k_s = rnd128();
        Req_B_Valid = 1'b1; Req_B_Text = t_s; Req_B_Key = k_s;
        tick();
        Req_B_Valid = 1'b0;
        wait_out(20);
        check("mid_b_src", W'(Out_Src), W'(1'b1));
        check("mid_b_data", Out_Data, aes128_encrypt(t_s, k_s));
        Out_Ready = 1'b1; tick(); Out_Ready = 1'b0;

        // Randomized traffic, backpressure and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            Req_A_Valid = ($urandom_range(0, 3) == 0);
            Req_B_Valid = ($urandom_range(0, 3) == 0);
            Req_A_Text = rnd128(); Req_A_Key = rnd128();
            Req_B_Text = rnd128(); Req_B_Key = rnd128();
            Out_Ready = ($urandom_range(0, 2) != 0);
            Rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        Rst_n = 1'b1;
        tick(); tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
